// File: rtl/wb_write_queue_if.sv
// Handshake, register-file write port and hazard-check bundle for wb_write_queue.
// Forwarding signals are present only when WBQ_FORWARD_EN is defined.
interface wb_write_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic [4:0]       wd_reg;
  logic [XLEN-1:0]  wdv;
  logic             wren;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [CNT_W-1:0] count;
  logic             empty;
`ifdef WBQ_FORWARD_EN
  logic             rs1_fwd_valid;
  logic [XLEN-1:0]  rs1_fwd_data;
  logic             rs2_fwd_valid;
  logic [XLEN-1:0]  rs2_fwd_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
    output alu_ready, mem_ready, wd_reg, wdv, wren, rs1_busy, rs2_busy, count, empty
`ifdef WBQ_FORWARD_EN
    , output rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs1, chk_rs2,
    input  alu_ready, mem_ready, wd_reg, wdv, wren, rs1_busy, rs2_busy, count, empty
`ifdef WBQ_FORWARD_EN
    , input rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
`endif
  );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback queue feeding the register-file write port, with operand busy flags.
// Optional macro WBQ_FORWARD_EN adds per-operand forwarding of the youngest pending write.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_write_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_wren;
  logic [4:0]       r_wd_reg;
  logic [XLEN-1:0]  r_wdv;

  logic             w_not_full;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic [4:0]       w_in_rd;
  logic [XLEN-1:0]  w_in_data;
  logic             w_push;
  logic             w_pop;

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign w_not_full    = r_count < CNT_W'(DEPTH);
  assign bus.mem_ready = w_not_full;
  assign bus.alu_ready = w_not_full && !bus.mem_valid;
  assign w_mem_acc     = bus.mem_valid && w_not_full;
  assign w_alu_acc     = bus.alu_valid && w_not_full && !bus.mem_valid;
  assign w_in_rd       = w_mem_acc ? bus.mem_rd   : bus.alu_rd;
  assign w_in_data     = w_mem_acc ? bus.mem_data : bus.alu_data;
  assign w_push        = (w_mem_acc || w_alu_acc) && (w_in_rd != 5'd0);
  assign w_pop         = r_count != '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_tail]   <= w_in_rd;
      r_data[r_tail] <= w_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_wren   <= 1'b0;
      r_wd_reg <= '0;
      r_wdv    <= '0;
    end else begin
      r_wren <= w_pop;
      if (w_pop) begin
        r_wd_reg <= r_rd[r_head];
        r_wdv    <= r_data[r_head];
        r_head   <= r_head + PTR_W'(1);
      end
      if (w_push)
        r_tail <= r_tail + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A register is busy while it sits in the queue or is being written this cycle.
  function automatic logic busy_of(input logic [4:0] rs);
    logic hit;
    hit = r_wren && (r_wd_reg == rs);
    for (int i = 0; i < DEPTH; i++)
      if ((CNT_W'(i) < r_count) && (r_rd[r_head + PTR_W'(i)] == rs))
        hit = 1'b1;
    return hit && (rs != 5'd0);
  endfunction

  assign bus.wren     = r_wren;
  assign bus.wd_reg   = r_wd_reg;
  assign bus.wdv      = r_wdv;
  assign bus.count    = r_count;
  assign bus.empty    = (r_count == '0);
  assign bus.rs1_busy = busy_of(bus.chk_rs1);
  assign bus.rs2_busy = busy_of(bus.chk_rs2);

`ifdef WBQ_FORWARD_EN
  // Walk oldest to youngest so the last match (closest to the tail) wins.
  function automatic logic [XLEN-1:0] fwd_of(input logic [4:0] rs);
    logic [XLEN-1:0] d;
    d = r_wdv;
    for (int i = 0; i < DEPTH; i++)
      if ((CNT_W'(i) < r_count) && (r_rd[r_head + PTR_W'(i)] == rs))
        d = r_data[r_head + PTR_W'(i)];
    return d;
  endfunction

  assign bus.rs1_fwd_valid = bus.rs1_busy;
  assign bus.rs2_fwd_valid = bus.rs2_busy;
  assign bus.rs1_fwd_data  = fwd_of(bus.chk_rs1);
  assign bus.rs2_fwd_data  = fwd_of(bus.chk_rs2);
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: directed scenarios followed by random traffic.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  wr_t mq[$];   // writes accepted but not yet retired
  wr_t sb[$];   // retirements the DUT must still present
  bit  m_wren;
  wr_t m_out;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_wren && m_out.rd == rs) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] m_fwd(input logic [4:0] rs);
    logic [XLEN-1:0] d;
    d = m_out.data;
    foreach (mq[i]) if (mq[i].rd == rs) d = mq[i].data;
    return d;
  endfunction

  // Reference model: retire the oldest write each cycle, then accept per priority/room.
  always @(posedge clk) begin : model
    bit room, am, aa;
    if (rst_n) begin
      room = mq.size() < DEPTH;
      am = bus.mem_valid && room;
      aa = bus.alu_valid && !bus.mem_valid && room;
      if (mq.size() > 0) begin
        m_out  = mq.pop_front();
        m_wren = 1'b1;
        sb.push_back(m_out);
      end else begin
        m_wren = 1'b0;
      end
      if (am && bus.mem_rd != 5'd0)
        mq.push_back({bus.mem_rd, bus.mem_data});
      else if (aa && bus.alu_rd != 5'd0)
        mq.push_back({bus.alu_rd, bus.alu_data});
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    check("wren", 64'(bus.wren), 64'(m_wren));
    if (bus.wren) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", bus.wd_reg, bus.wdv);
      end else begin
        e = sb.pop_front();
        check("retire_rd", 64'(bus.wd_reg), 64'(e.rd));
        check("retire_data", 64'(bus.wdv), 64'(e.data));
      end
    end else begin
      check("hold_rd", 64'(bus.wd_reg), 64'(m_out.rd));
      check("hold_data", 64'(bus.wdv), 64'(m_out.data));
    end
    check("count", 64'(bus.count), 64'(mq.size()));
    check("empty", 64'(bus.empty), 64'(mq.size() == 0));
    check("mem_ready", 64'(bus.mem_ready), 64'(mq.size() < DEPTH));
    check("alu_ready", 64'(bus.alu_ready), 64'(mq.size() < DEPTH && !bus.mem_valid));
    check("rs1_busy", 64'(bus.rs1_busy), 64'(m_busy(bus.chk_rs1)));
    check("rs2_busy", 64'(bus.rs2_busy), 64'(m_busy(bus.chk_rs2)));
`ifdef WBQ_FORWARD_EN
    check("rs1_fwd_valid", 64'(bus.rs1_fwd_valid), 64'(m_busy(bus.chk_rs1)));
    check("rs2_fwd_valid", 64'(bus.rs2_fwd_valid), 64'(m_busy(bus.chk_rs2)));
    if (m_busy(bus.chk_rs1)) check("rs1_fwd_data", 64'(bus.rs1_fwd_data), 64'(m_fwd(bus.chk_rs1)));
    if (m_busy(bus.chk_rs2)) check("rs2_fwd_data", 64'(bus.rs2_fwd_data), 64'(m_fwd(bus.chk_rs2)));
`endif
  end

  task automatic drive(input bit mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                       input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input logic [4:0] c1, input logic [4:0] c2);
    bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    bus.chk_rs1   = c1;  bus.chk_rs2 = c2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] c1, input logic [4:0] c2);
    repeat (n) drive(0, 5'd0, '0, 0, 5'd0, '0, c1, c2);
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_wren = 1'b0;
    m_out  = '0;
  endtask

  initial begin
    model_clear();
    bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.chk_rs1 = 5'd5; bus.chk_rs2 = 5'd0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_wren", 64'(bus.wren), 64'd0);
    check("rst_wd_reg", 64'(bus.wd_reg), 64'd0);
    check("rst_wdv", 64'(bus.wdv), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_busy", 64'(bus.rs1_busy), 64'd0);
    idle(2, 5'd5, 5'd0);

    // Single write, observe busy window on rs1=3
    drive(0, 5'd0, '0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
    idle(4, 5'd3, 5'd0);

    // Load wins over ALU, then ALU goes through
    drive(1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 5'd4, 5'd5);
    drive(0, 5'd0, '0, 1, 5'd5, 32'h22, 5'd4, 5'd5);
    idle(3, 5'd4, 5'd5);

    // Sustained traffic from both sources
    for (int i = 0; i < 6; i++)
      drive(1, 5'(i + 1), 32'h100 + 32'(i), 1, 5'd9, 32'h200 + 32'(i), 5'(i + 1), 5'd9);
    idle(3, 5'd1, 5'd9);

    // x0 is accepted but dropped; same-rd writes retire in order
    drive(0, 5'd0, '0, 1, 5'd0, 32'h1, 5'd7, 5'd0);
    drive(0, 5'd0, '0, 1, 5'd7, 32'hA, 5'd7, 5'd0);
    drive(0, 5'd0, '0, 1, 5'd7, 32'hB, 5'd7, 5'd0);
    idle(4, 5'd7, 5'd0);

    // Asynchronous reset while writes are in flight
    drive(1, 5'd10, 32'hAAA, 0, 5'd0, '0, 5'd10, 5'd11);
    drive(1, 5'd11, 32'hBBB, 0, 5'd0, '0, 5'd10, 5'd11);
    drive(1, 5'd12, 32'hCCC, 0, 5'd0, '0, 5'd10, 5'd11);
    bus.mem_valid = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("arst_wren", 64'(bus.wren), 64'd0);
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_busy", 64'(bus.rs1_busy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5, 5'd10, 5'd12);

    // Random traffic with a small register range to provoke collisions
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    idle(6, 5'd0, 5'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("model_drained", 64'(mq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
